// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: NRD-read/2-write register file with optional write bypass and busy scoreboard (ports: clk, rst_n, rd_addr/rd_data/rd_busy, wa_*, wb_*, iss_*, busy_cnt)
module regfile_mp_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NRD    = 3,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wa_valid,
  input  logic [AW-1:0]       wa_rd,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [AW:0]         busy_cnt
);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy, busy_nxt;
  logic [AW:0]     cnt_nxt;
  logic            wa_en, wb_en, iss_en;
  assign wa_en  = wa_valid && wa_rd != '0;
  assign wb_en  = wb_valid && wb_rd != '0;
  assign iss_en = iss_valid && iss_rd != '0;
  always_comb begin
    busy_nxt = busy;
    if (wa_en) busy_nxt[wa_rd] = 1'b0;
    if (wb_en) busy_nxt[wb_rd] = 1'b0;
    if (iss_en) busy_nxt[iss_rd] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      if (wb_en) regs[wb_rd] <= wb_data;
      if (wa_en) regs[wa_rd] <= wa_data;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[k*AW +: AW];
    assign rd_data[k*XLEN +: XLEN] = a == '0 ? '0 :
                                     (BYPASS != 0 && wa_valid && wa_rd == a) ? wa_data :
                                     (BYPASS != 0 && wb_valid && wb_rd == a) ? wb_data :
                                     regs[a];
    assign rd_busy[k] = busy[a];
  end
endmodule
